dsp_ch_sched: RTL
=================

# dsp_ch_sched

Per-sample scheduler for the eight `dsp_ch` voices inside the DSP. It runs a fixed 320-clock frame, which is one 32 kHz output sample at 10.24 MHz. Within each frame it gives every voice a 32-clock slot, generates the one-hot access and calculation strobes each voice needs, and muxes the voices' ARAM addresses onto the two shared ARAM read ports. It also latches CPU KON/KOFF writes and releases them to the voices on the frame boundary, and it grants the ARAM to the echo unit in the tail window of the frame.

## Interface
- `NUM_CH`, default 8: voice count; fixed at 8 in this design.
- `clk`  in  1  10.24 MHz system clock.
- `reset`  in  1  synchronous, active-low reset; 0 = reset.
- `kon_wr`  in  1  one-cycle strobe: KON register write.
- `kon_data`  in  8  KON bits, bit n = voice n.
- `koff_wr`  in  1  one-cycle strobe: KOFF register write.
- `koff_data`  in  8  KOFF bits.
- `ch_src_addr`  in  8×15  per-voice `src_addr`.
- `ch_brr_control_addr`  in  8×16  per-voice `brr_control_addr`.
- `ch_brr_sample_addr_0`  in  8×16  per-voice sample address, port 0.
- `ch_brr_sample_addr_1`  in  8×16  per-voice sample address, port 1.
- `echo_req`  in  1  echo unit requests an ARAM cycle.
- `echo_addr_0`  in  16  echo read/write address, port 0.
- `echo_addr_1`  in  16  echo read/write address, port 1.
- `aram_addr_0`  out  16  shared ARAM port 0 address.
- `aram_addr_1`  out  16  shared ARAM port 1 address.
- `echo_gnt`  out  1  echo owns ARAM this cycle.
- `src_access`  out  8  one-hot: voice captures SRC directory data.
- `brr_control_access`  out  8  one-hot: voice captures BRR header.
- `brr_sample_access`  out  8  one-hot: voice captures BRR sample bytes.
- `pcm_calc`  out  8  one-hot: voice performs a PCM/interpolation step.
- `pcm_calc_num`  out  2  step index qualifying `pcm_calc`.
- `exe_32khz`  out  1  frame-end pulse, broadcast to all voices.
- `key_on`  out  8  per-voice key-on, frame-stable.
- `key_off`  out  8  per-voice key-off, frame-stable.
- `slot_ch`  out  3  voice owning the current slot.
- `mix_en`  out  1  pulse: voice outputs are final and the mixer may sum them.

## Operation
- Frame counter `cnt`:
  - Counts 0..319 and wraps 319→0.
  - Voice window is `cnt` < 256: `slot_ch = cnt[7:5]`, phase `ph = cnt[4:0]`.
  - Echo window is 256 ≤ `cnt` ≤ 318. `slot_ch` holds 7 outside the voice window.
- ARAM has 1-cycle read latency. The address is driven at phase p and the capture strobe fires at p+1.
- Voice-window sequence for voice c = `slot_ch`:
  - ph 0: `aram_addr_0 = {src_addr,0}`, `aram_addr_1 = {src_addr,1}`.
  - ph 1: `src_access[c]`.
  - ph 2: both ports = `brr_control_addr`.
  - ph 3: `brr_control_access[c]`.
  - ph 4: ports = `brr_sample_addr_0/1`.
  - ph 5: `brr_sample_access[c]`.
  - ph 8, 10, 12, 14: `pcm_calc[c]`, with `pcm_calc_num` = 0, 1, 2, 3 respectively.
  - All other phases: ARAM addresses 0; no strobe.
- Strobes:
  - All strobes are registered and last exactly one cycle. At most one bit of any strobe vector is set.
  - `pcm_calc_num` is 0 whenever `pcm_calc` = 0.
- Echo window:
  - `echo_gnt = echo_req` while `cnt` is in 256..318. `echo_gnt` is combinational.
  - When `echo_gnt` = 1, `aram_addr_0/1 = echo_addr_0/1`; otherwise the ARAM addresses are 0.
  - A request outside the window waits, ungranted, until `cnt` = 256. It is never dropped.
  - `mix_en` pulses at `cnt` = 256.
- `exe_32khz` pulses at `cnt` = 319.
- KON:
  - `kon_wr` ORs `kon_data` into `kon_pend`.
  - At `cnt` = 319: `key_on <= kon_pend | (kon_wr ? kon_data : 0)` and `kon_pend <= 0`.
  - A write in the 319 cycle therefore lands in this frame and is not lost.
  - `key_on` is held for the whole following frame, so the voice samples it on the next `exe_32khz`.
- KOFF:
  - `koff_wr` overwrites `koff_pend`, which is level-held, not cleared.
  - At `cnt` = 319: `key_off <= koff_wr ? koff_data : koff_pend`.
- Reset (`reset` = 0, any cycle):
  - `cnt` = 0.
  - All strobes, `exe_32khz`, `mix_en`, `key_on`, `key_off`, `kon_pend`, `koff_pend` = 0.
  - ARAM addresses = 0, `slot_ch` = 0.
- Reset mid-frame: the frame restarts at `cnt` = 0 and no partial `exe_32khz` is issued.

## Timing
- Reset release: the first clock with `reset` = 1 has `cnt` = 0. `src_access[0]` is at `cnt` = 1 and the first `exe_32khz` is at `cnt` = 319.
- Period of every strobe is exactly 320 clocks.
- `key_on`/`key_off` change only on the clock edge leaving `cnt` = 319.
- `echo_gnt` can be high on at most 63 cycles per frame.

## Test plan
- Release reset, run 2 frames → `src_access` = 0x01 at `cnt` 1, 0x08 at 97, 0x80 at 225. `exe_32khz` is high only at 319 and 639. `mix_en` is high at 256 and 576.
- Set `ch_src_addr[3]` = 0x1234, `ch_brr_control_addr[3]` = 0xBEEF → at `cnt` 96: `aram_addr_0/1` = 0x2468/0x2469. At 98: both ports = 0xBEEF. At 99: `brr_control_access` = 0x08.
- `kon_wr` with 0x05 at `cnt` 100, then 0x80 at `cnt` 319 → `key_on` = 0x85 from `cnt` 320 through 639, and 0x00 after the next 319.
- `koff_wr` with 0x0F at `cnt` 50 → `key_off` = 0x0F from `cnt` 320 and stays 0x0F on following frames.
- Hold `echo_req` high with `echo_addr_0` = 0x4000 from `cnt` 200 → `echo_gnt` = 0 through 255. `echo_gnt` = 1 and `aram_addr_0` = 0x4000 for `cnt` 256..318. `echo_gnt` = 0 at 319.
- Pull `reset` low at `cnt` 150 for 1 cycle → all outputs are 0 in the reset cycle, `src_access[0]` fires 2 cycles later, and no `exe_32khz` occurs until 320 clocks after release.

Source files
------------

// File: rtl/dsp_ch_sched.sv
// Frame scheduler for the eight dsp_ch voices: 320-clock frame, 32-clock voice slots,
// one-hot capture/calc strobes, shared ARAM address mux, KON/KOFF latching and echo grant.
module dsp_ch_sched #(
  parameter int NUM_CH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     kon_wr,
  input  logic [NUM_CH-1:0]        kon_data,
  input  logic                     koff_wr,
  input  logic [NUM_CH-1:0]        koff_data,
  input  logic [NUM_CH-1:0][14:0]  ch_src_addr,
  input  logic [NUM_CH-1:0][15:0]  ch_brr_control_addr,
  input  logic [NUM_CH-1:0][15:0]  ch_brr_sample_addr_0,
  input  logic [NUM_CH-1:0][15:0]  ch_brr_sample_addr_1,
  input  logic                     echo_req,
  input  logic [15:0]              echo_addr_0,
  input  logic [15:0]              echo_addr_1,
  output logic [15:0]              aram_addr_0,
  output logic [15:0]              aram_addr_1,
  output logic                     echo_gnt,
  output logic [NUM_CH-1:0]        src_access,
  output logic [NUM_CH-1:0]        brr_control_access,
  output logic [NUM_CH-1:0]        brr_sample_access,
  output logic [NUM_CH-1:0]        pcm_calc,
  output logic [1:0]               pcm_calc_num,
  output logic                     exe_32khz,
  output logic [NUM_CH-1:0]        key_on,
  output logic [NUM_CH-1:0]        key_off,
  output logic [2:0]               slot_ch,
  output logic                     mix_en
);

  localparam logic [8:0] CNT_LAST   = 9'd319;
  localparam logic [8:0] ECHO_FIRST = 9'd256;
  localparam logic [8:0] ECHO_LAST  = 9'd318;

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [2:0] ch);
    logic [NUM_CH-1:0] vec;
    vec     = {NUM_CH{1'b0}};
    vec[ch] = 1'b1;
    return vec;
  endfunction

  logic [8:0]        cnt_q, cnt_d;
  logic [2:0]        slot_ch_q, slot_ch_d;
  logic [15:0]       voice_addr_0_q, voice_addr_0_d;
  logic [15:0]       voice_addr_1_q, voice_addr_1_d;
  logic [NUM_CH-1:0] src_access_q, src_access_d;
  logic [NUM_CH-1:0] brr_control_access_q, brr_control_access_d;
  logic [NUM_CH-1:0] brr_sample_access_q, brr_sample_access_d;
  logic [NUM_CH-1:0] pcm_calc_q, pcm_calc_d;
  logic [1:0]        pcm_calc_num_q, pcm_calc_num_d;
  logic              exe_32khz_q, exe_32khz_d;
  logic              mix_en_q, mix_en_d;
  logic [NUM_CH-1:0] kon_pend_q, kon_pend_d;
  logic [NUM_CH-1:0] koff_pend_q, koff_pend_d;
  logic [NUM_CH-1:0] key_on_q, key_on_d;
  logic [NUM_CH-1:0] key_off_q, key_off_d;

  logic              voice_win_d;
  logic [2:0]        slot_d;
  logic [4:0]        ph_d;
  logic [NUM_CH-1:0] kon_in;
  logic              echo_win;

  // Frame counter; reset restarts the frame so no partial exe_32khz can be issued.
  always_comb begin
    cnt_d = cnt_q;
    if (!reset) begin
      cnt_d = 9'd0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = 9'd0;
    end else begin
      cnt_d = cnt_q + 9'd1;
    end
  end

  // Strobes and voice addresses are decoded from the next count so the registered
  // outputs line up with the count value of the cycle in which they are visible.
  always_comb begin
    voice_win_d          = ~cnt_d[8];
    slot_d               = voice_win_d ? cnt_d[7:5] : 3'd7;
    ph_d                 = cnt_d[4:0];
    slot_ch_d            = slot_d;
    voice_addr_0_d       = 16'h0000;
    voice_addr_1_d       = 16'h0000;
    src_access_d         = {NUM_CH{1'b0}};
    brr_control_access_d = {NUM_CH{1'b0}};
    brr_sample_access_d  = {NUM_CH{1'b0}};
    pcm_calc_d           = {NUM_CH{1'b0}};
    pcm_calc_num_d       = 2'd0;
    exe_32khz_d          = reset && (cnt_d == CNT_LAST);
    mix_en_d             = reset && (cnt_d == ECHO_FIRST);
    if (!reset) begin
      slot_ch_d = 3'd0;
    end else if (voice_win_d) begin
      case (ph_d)
        5'd0: begin
          voice_addr_0_d = {ch_src_addr[slot_d], 1'b0};
          voice_addr_1_d = {ch_src_addr[slot_d], 1'b1};
        end
        5'd1: src_access_d = ch_onehot(slot_d);
        5'd2: begin
          voice_addr_0_d = ch_brr_control_addr[slot_d];
          voice_addr_1_d = ch_brr_control_addr[slot_d];
        end
        5'd3: brr_control_access_d = ch_onehot(slot_d);
        5'd4: begin
          voice_addr_0_d = ch_brr_sample_addr_0[slot_d];
          voice_addr_1_d = ch_brr_sample_addr_1[slot_d];
        end
        5'd5: brr_sample_access_d = ch_onehot(slot_d);
        5'd8, 5'd10, 5'd12, 5'd14: begin
          pcm_calc_d     = ch_onehot(slot_d);
          pcm_calc_num_d = ph_d[2:1];
        end
        default: begin
          voice_addr_0_d = 16'h0000;
          voice_addr_1_d = 16'h0000;
        end
      endcase
    end else begin
      slot_ch_d = 3'd7;
    end
  end

  // KON accumulates until the frame boundary; a write in the 319 cycle is folded in directly.
  always_comb begin
    kon_in      = kon_wr ? kon_data : {NUM_CH{1'b0}};
    kon_pend_d  = kon_pend_q | kon_in;
    koff_pend_d = koff_wr ? koff_data : koff_pend_q;
    key_on_d    = key_on_q;
    key_off_d   = key_off_q;
    if (!reset) begin
      kon_pend_d  = {NUM_CH{1'b0}};
      koff_pend_d = {NUM_CH{1'b0}};
      key_on_d    = {NUM_CH{1'b0}};
      key_off_d   = {NUM_CH{1'b0}};
    end else if (cnt_q == CNT_LAST) begin
      key_on_d   = kon_pend_q | kon_in;
      kon_pend_d = {NUM_CH{1'b0}};
      key_off_d  = koff_wr ? koff_data : koff_pend_q;
    end else begin
      key_on_d  = key_on_q;
      key_off_d = key_off_q;
    end
  end

  // State register; next-state logic above already folds in the synchronous reset.
  always_ff @(posedge clk) begin
    cnt_q                <= cnt_d;
    slot_ch_q            <= slot_ch_d;
    voice_addr_0_q       <= voice_addr_0_d;
    voice_addr_1_q       <= voice_addr_1_d;
    src_access_q         <= src_access_d;
    brr_control_access_q <= brr_control_access_d;
    brr_sample_access_q  <= brr_sample_access_d;
    pcm_calc_q           <= pcm_calc_d;
    pcm_calc_num_q       <= pcm_calc_num_d;
    exe_32khz_q          <= exe_32khz_d;
    mix_en_q             <= mix_en_d;
    kon_pend_q           <= kon_pend_d;
    koff_pend_q          <= koff_pend_d;
    key_on_q             <= key_on_d;
    key_off_q            <= key_off_d;
  end

  // Echo grant is combinational so a held request is served the moment the window opens.
  assign echo_win    = (cnt_q >= ECHO_FIRST) && (cnt_q <= ECHO_LAST);
  assign echo_gnt    = reset && echo_req && echo_win;
  assign aram_addr_0 = echo_gnt ? echo_addr_0 : voice_addr_0_q;
  assign aram_addr_1 = echo_gnt ? echo_addr_1 : voice_addr_1_q;

  assign src_access         = src_access_q;
  assign brr_control_access = brr_control_access_q;
  assign brr_sample_access  = brr_sample_access_q;
  assign pcm_calc           = pcm_calc_q;
  assign pcm_calc_num       = pcm_calc_num_q;
  assign exe_32khz          = exe_32khz_q;
  assign mix_en             = mix_en_q;
  assign key_on             = key_on_q;
  assign key_off            = key_off_q;
  assign slot_ch            = slot_ch_q;

endmodule
